// File: rtl/rocc_dispatch.sv
// RoCC command/response dispatcher: buffers core commands, routes them to one of
// NUM_ACC accelerators by funct7, and merges accelerator responses. Define
// ROCC_DISPATCH_RR_EN for round-robin response arbitration (fixed priority otherwise).
module rocc_dispatch #(
  parameter int NUM_ACC            = 4,
  parameter int ACC_DATA_WIDTH     = 64,
  parameter int ACC_INSTR_WIDTH    = 32,
  parameter int ACC_REG_ADDR_WIDTH = 5,
  parameter int CMD_FIFO_DEPTH     = 4,
  parameter int RESP_FIFO_DEPTH    = 4,
  parameter int MAX_OUTSTANDING    = 8,
  parameter int IDX_W              = $clog2(NUM_ACC)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     cmd_valid_i,
  output logic                                     cmd_ready_o,
  input  logic [ACC_INSTR_WIDTH-1:0]               cmd_instr_i,
  input  logic [ACC_DATA_WIDTH-1:0]                cmd_rs1_i,
  input  logic [ACC_DATA_WIDTH-1:0]                cmd_rs2_i,
  output logic                                     resp_valid_o,
  input  logic                                     resp_ready_i,
  output logic [ACC_DATA_WIDTH-1:0]                resp_data_o,
  output logic [ACC_REG_ADDR_WIDTH-1:0]            resp_rd_o,
  output logic [NUM_ACC-1:0]                       acc_cmd_valid_o,
  input  logic [NUM_ACC-1:0]                       acc_cmd_ready_i,
  output logic [ACC_INSTR_WIDTH-1:0]               acc_cmd_instr_o,
  output logic [ACC_DATA_WIDTH-1:0]                acc_cmd_rs1_o,
  output logic [ACC_DATA_WIDTH-1:0]                acc_cmd_rs2_o,
  input  logic [NUM_ACC-1:0]                       acc_resp_valid_i,
  output logic [NUM_ACC-1:0]                       acc_resp_ready_o,
  input  logic [NUM_ACC*ACC_DATA_WIDTH-1:0]        acc_resp_data_i,
  input  logic [NUM_ACC*ACC_REG_ADDR_WIDTH-1:0]    acc_resp_rd_i,
  output logic                                     busy_o,
  output logic                                     cmd_err_o
);

  localparam int CMD_AW  = $clog2(CMD_FIFO_DEPTH);
  localparam int RESP_AW = $clog2(RESP_FIFO_DEPTH);
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W:0]     NUM_ACC_L = (IDX_W + 1)'(NUM_ACC);
  localparam logic [CNT_W-1:0]   MAX_OUT_L = CNT_W'(MAX_OUTSTANDING);

  // Command buffer: storage is not reset, only the pointers are.
  logic [ACC_INSTR_WIDTH-1:0] cmd_instr_mem [CMD_FIFO_DEPTH];
  logic [ACC_DATA_WIDTH-1:0]  cmd_rs1_mem   [CMD_FIFO_DEPTH];
  logic [ACC_DATA_WIDTH-1:0]  cmd_rs2_mem   [CMD_FIFO_DEPTH];
  logic [CMD_AW:0]            cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, cmd_rptr_d;
  logic                       cmd_empty, cmd_full, cmd_push, cmd_pop, cmd_hs;

  logic [ACC_INSTR_WIDTH-1:0] head_instr;
  logic [ACC_DATA_WIDTH-1:0]  head_rs1, head_rs2;
  logic [IDX_W-1:0]           head_idx;
  logic                       head_xd, head_legal, stall, dispatch_req;

  logic [CNT_W-1:0]           out_cnt_q, out_cnt_d;
  logic                       resp_hs, cnt_inc, cnt_dec;

  logic [ACC_DATA_WIDTH-1:0]     resp_data_mem [RESP_FIFO_DEPTH];
  logic [ACC_REG_ADDR_WIDTH-1:0] resp_rd_mem   [RESP_FIFO_DEPTH];
  logic [RESP_AW:0]              resp_wptr_q, resp_wptr_d, resp_rptr_q, resp_rptr_d;
  logic                          resp_empty, resp_full, resp_push;

  logic [NUM_ACC-1:0]         grant;
  logic [IDX_W-1:0]           grant_idx;

  assign cmd_empty = (cmd_wptr_q == cmd_rptr_q);
  assign cmd_full  = (cmd_wptr_q[CMD_AW] != cmd_rptr_q[CMD_AW]) &&
                     (cmd_wptr_q[CMD_AW-1:0] == cmd_rptr_q[CMD_AW-1:0]);
  assign cmd_ready_o = !cmd_full;
  assign cmd_push    = cmd_valid_i && !cmd_full;

  // Payload reads as zero while empty so outputs are defined without resetting storage.
  always_comb begin
    head_instr = '0;
    head_rs1   = '0;
    head_rs2   = '0;
    if (!cmd_empty) begin
      head_instr = cmd_instr_mem[cmd_rptr_q[CMD_AW-1:0]];
      head_rs1   = cmd_rs1_mem[cmd_rptr_q[CMD_AW-1:0]];
      head_rs2   = cmd_rs2_mem[cmd_rptr_q[CMD_AW-1:0]];
    end
  end

  assign head_idx     = head_instr[25 +: IDX_W];
  assign head_xd      = head_instr[14];
  assign head_legal   = ({1'b0, head_idx} < NUM_ACC_L);
  assign stall        = head_xd && (out_cnt_q == MAX_OUT_L);
  assign dispatch_req = !cmd_empty && head_legal && !stall;

  assign acc_cmd_instr_o = head_instr;
  assign acc_cmd_rs1_o   = head_rs1;
  assign acc_cmd_rs2_o   = head_rs2;

  always_comb begin
    acc_cmd_valid_o = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (dispatch_req && (head_idx == IDX_W'(i))) acc_cmd_valid_o[i] = 1'b1;
    end
  end

  // An illegal head is dropped in the cycle it surfaces, flagged by cmd_err_o.
  assign cmd_hs    = |(acc_cmd_valid_o & acc_cmd_ready_i);
  assign cmd_err_o = !cmd_empty && !head_legal;
  assign cmd_pop   = cmd_hs || cmd_err_o;

  always_comb begin
    cmd_wptr_d = cmd_wptr_q;
    cmd_rptr_d = cmd_rptr_q;
    if (cmd_push) cmd_wptr_d = cmd_wptr_q + (CMD_AW + 1)'(1);
    if (cmd_pop)  cmd_rptr_d = cmd_rptr_q + (CMD_AW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (cmd_push) begin
      cmd_instr_mem[cmd_wptr_q[CMD_AW-1:0]] <= cmd_instr_i;
      cmd_rs1_mem[cmd_wptr_q[CMD_AW-1:0]]   <= cmd_rs1_i;
      cmd_rs2_mem[cmd_wptr_q[CMD_AW-1:0]]   <= cmd_rs2_i;
    end
  end

  // Outstanding xd=1 commands; saturates at zero when an unsolicited response drains.
  assign resp_hs = resp_valid_o && resp_ready_i;
  assign cnt_inc = cmd_hs && head_xd;
  assign cnt_dec = resp_hs && (out_cnt_q != '0);

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (cnt_inc && !cnt_dec)      out_cnt_d = out_cnt_q + CNT_W'(1);
    else if (cnt_dec && !cnt_inc) out_cnt_d = out_cnt_q - CNT_W'(1);
  end

  assign busy_o = !cmd_empty || (out_cnt_q != '0);

`ifdef ROCC_DISPATCH_RR_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int  j;
    logic found;
    j         = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_ACC; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_ACC) j = j - NUM_ACC;
      if (!found && acc_resp_valid_i[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (resp_push) rr_ptr_d = (grant_idx == IDX_W'(NUM_ACC - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    logic found;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_ACC; k++) begin
      if (!found && acc_resp_valid_i[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end
`endif

  assign resp_empty = (resp_wptr_q == resp_rptr_q);
  assign resp_full  = (resp_wptr_q[RESP_AW] != resp_rptr_q[RESP_AW]) &&
                      (resp_wptr_q[RESP_AW-1:0] == resp_rptr_q[RESP_AW-1:0]);
  assign acc_resp_ready_o = resp_full ? '0 : grant;
  assign resp_push        = |acc_resp_ready_o;
  assign resp_valid_o     = !resp_empty;
  assign resp_data_o      = resp_empty ? '0 : resp_data_mem[resp_rptr_q[RESP_AW-1:0]];
  assign resp_rd_o        = resp_empty ? '0 : resp_rd_mem[resp_rptr_q[RESP_AW-1:0]];

  always_comb begin
    resp_wptr_d = resp_wptr_q;
    resp_rptr_d = resp_rptr_q;
    if (resp_push) resp_wptr_d = resp_wptr_q + (RESP_AW + 1)'(1);
    if (resp_hs)   resp_rptr_d = resp_rptr_q + (RESP_AW + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (resp_push) begin
      resp_data_mem[resp_wptr_q[RESP_AW-1:0]] <=
        acc_resp_data_i[int'(grant_idx)*ACC_DATA_WIDTH +: ACC_DATA_WIDTH];
      resp_rd_mem[resp_wptr_q[RESP_AW-1:0]] <=
        acc_resp_rd_i[int'(grant_idx)*ACC_REG_ADDR_WIDTH +: ACC_REG_ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_wptr_q  <= '0;
      cmd_rptr_q  <= '0;
      resp_wptr_q <= '0;
      resp_rptr_q <= '0;
      out_cnt_q   <= '0;
    end else begin
      cmd_wptr_q  <= cmd_wptr_d;
      cmd_rptr_q  <= cmd_rptr_d;
      resp_wptr_q <= resp_wptr_d;
      resp_rptr_q <= resp_rptr_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_rocc_dispatch.sv
// Directed bench for rocc_dispatch with a dispatch/response scoreboard; a second
// NUM_ACC=3 instance exercises the illegal-index path.
module tb_rocc_dispatch;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_instr;
  logic [63:0]  cmd_rs1, cmd_rs2;
  logic         resp_valid;
  logic         resp_ready;
  logic [63:0]  resp_data;
  logic [4:0]   resp_rd;
  logic [3:0]   acc_cmd_valid, acc_cmd_ready;
  logic [31:0]  acc_cmd_instr;
  logic [63:0]  acc_cmd_rs1, acc_cmd_rs2;
  logic [3:0]   acc_resp_valid, acc_resp_ready;
  logic [255:0] acc_resp_data;
  logic [19:0]  acc_resp_rd;
  logic         busy, cmd_err;

  logic         c3_cmd_valid, c3_cmd_ready;
  logic [31:0]  c3_cmd_instr;
  logic [63:0]  c3_zero64;
  logic         c3_resp_valid, c3_resp_ready;
  logic [63:0]  c3_resp_data;
  logic [4:0]   c3_resp_rd;
  logic [2:0]   c3_acc_cmd_valid, c3_acc_cmd_ready;
  logic [31:0]  c3_acc_cmd_instr;
  logic [63:0]  c3_acc_cmd_rs1, c3_acc_cmd_rs2;
  logic [2:0]   c3_acc_resp_valid, c3_acc_resp_ready;
  logic [191:0] c3_acc_resp_data;
  logic [14:0]  c3_acc_resp_rd;
  logic         c3_busy, c3_err;

  always #5 clk = ~clk;

  rocc_dispatch dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_instr_i(cmd_instr),
    .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_rd_o(resp_rd),
    .acc_cmd_valid_o(acc_cmd_valid), .acc_cmd_ready_i(acc_cmd_ready),
    .acc_cmd_instr_o(acc_cmd_instr), .acc_cmd_rs1_o(acc_cmd_rs1), .acc_cmd_rs2_o(acc_cmd_rs2),
    .acc_resp_valid_i(acc_resp_valid), .acc_resp_ready_o(acc_resp_ready),
    .acc_resp_data_i(acc_resp_data), .acc_resp_rd_i(acc_resp_rd),
    .busy_o(busy), .cmd_err_o(cmd_err)
  );

  rocc_dispatch #(.NUM_ACC(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(c3_cmd_valid), .cmd_ready_o(c3_cmd_ready), .cmd_instr_i(c3_cmd_instr),
    .cmd_rs1_i(c3_zero64), .cmd_rs2_i(c3_zero64),
    .resp_valid_o(c3_resp_valid), .resp_ready_i(c3_resp_ready),
    .resp_data_o(c3_resp_data), .resp_rd_o(c3_resp_rd),
    .acc_cmd_valid_o(c3_acc_cmd_valid), .acc_cmd_ready_i(c3_acc_cmd_ready),
    .acc_cmd_instr_o(c3_acc_cmd_instr), .acc_cmd_rs1_o(c3_acc_cmd_rs1), .acc_cmd_rs2_o(c3_acc_cmd_rs2),
    .acc_resp_valid_i(c3_acc_resp_valid), .acc_resp_ready_o(c3_acc_resp_ready),
    .acc_resp_data_i(c3_acc_resp_data), .acc_resp_rd_i(c3_acc_resp_rd),
    .busy_o(c3_busy), .cmd_err_o(c3_err)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } cmd_e_t;

  cmd_e_t      cmd_q[$];
  logic [68:0] resp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          m_cnt = 0;
  int          m_ptr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int acc, input bit xd, input logic [4:0] tag);
    logic [31:0] i;
    i         = 32'h0000_000b;
    i[31:25]  = 7'(acc);
    i[14]     = xd;
    i[11:7]   = tag;
    return i;
  endfunction

  function automatic logic [3:0] exp_grant(input logic [3:0] v, input int ptr);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = (ptr + k) % 4;
      if (v[j]) return 4'b0001 << j;
    end
    return 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one command, waiting (bounded) for cmd_ready, and records its expected dispatch.
  task automatic push_cmd(input int acc, input bit xd, input logic [4:0] tag,
                          input logic [63:0] r1, input logic [63:0] r2);
    cmd_e_t e;
    int     n;
    cmd_valid = 1'b1;
    cmd_instr = mk_instr(acc, xd, tag);
    cmd_rs1   = r1;
    cmd_rs2   = r2;
    #1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", cmd_ready, 1'b1);
    e.sel   = 4'b0001 << acc;
    e.instr = cmd_instr;
    e.rs1   = r1;
    e.rs2   = r2;
    cmd_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  cmd_e_t      me;
  logic [68:0] mr;
  logic [3:0]  m_er;
  int          mi;

  always @(negedge clk) begin
    if (rst_n) begin
      if ((acc_cmd_valid & acc_cmd_ready) != 4'b0) begin
        if (cmd_q.size() == 0) chk("disp_extra", acc_cmd_valid, 4'b0);
        else begin
          me = cmd_q.pop_front();
          chk("disp_sel", acc_cmd_valid, me.sel);
          chk("disp_instr", acc_cmd_instr, me.instr);
          chk("disp_rs1", acc_cmd_rs1, me.rs1);
          chk("disp_rs2", acc_cmd_rs2, me.rs2);
        end
      end
      m_er = (m_cnt == 4) ? 4'b0 : exp_grant(acc_resp_valid, m_ptr);
      chk("resp_valid_model", resp_valid, m_cnt != 0);
      if (acc_resp_valid != 4'b0) chk("arb_ready", acc_resp_ready, m_er);
      if (resp_valid && resp_ready) begin
        if (resp_q.size() == 0) chk("resp_extra", resp_valid, 1'b0);
        else begin
          mr = resp_q.pop_front();
          chk("resp_data", resp_data, mr[63:0]);
          chk("resp_rd", resp_rd, mr[68:64]);
        end
        m_cnt--;
      end
      if (m_er != 4'b0) begin
        mi = 0;
        for (int k = 0; k < 4; k++) if (m_er[k]) mi = k;
        resp_q.push_back({acc_resp_rd[mi*5 +: 5], acc_resp_data[mi*64 +: 64]});
        m_cnt++;
`ifdef ROCC_DISPATCH_RR_EN
        m_ptr = (mi + 1) % 4;
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_err=%0d n_chk=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  logic [3:0] arb_seq [5];

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_instr = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    resp_ready = 1'b0; acc_cmd_ready = '0; acc_resp_valid = '0;
    acc_resp_data = '0; acc_resp_rd = '0;
    c3_cmd_valid = 1'b0; c3_cmd_instr = '0; c3_zero64 = '0; c3_resp_ready = 1'b0;
    c3_acc_cmd_ready = '0; c3_acc_resp_valid = '0; c3_acc_resp_data = '0; c3_acc_resp_rd = '0;

    // Reset values
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_acc_cmd_valid", acc_cmd_valid, 4'b0);
    chk("rst_acc_resp_ready", acc_resp_ready, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("rst_payload", acc_cmd_rs1, 64'h0);
    #1 rst_n = 1'b1;
    tick();

    // Route: funct7=2, xd=1 goes to accelerator 2 one cycle after acceptance
    push_cmd(2, 1'b1, 5'd1, 64'h11, 64'h22);
    #1;
    chk("route_valid", acc_cmd_valid, 4'b0100);
    chk("route_rs1", acc_cmd_rs1, 64'h11);
    chk("route_busy", busy, 1'b1);
    acc_cmd_ready = 4'hf;
    tick();
    acc_cmd_ready = 4'h0;
    #1;
    chk("route_done_valid", acc_cmd_valid, 4'b0);
    chk("route_cnt_busy", busy, 1'b1);
    acc_resp_data[2*64 +: 64] = 64'hA2;
    acc_resp_rd[2*5 +: 5] = 5'd3;
    acc_resp_valid = 4'b0100;
    tick();
    acc_resp_valid = 4'b0;
    #1;
    chk("route_resp_valid", resp_valid, 1'b1);
    chk("route_resp_data", resp_data, 64'hA2);
    chk("route_resp_rd", resp_rd, 5'd3);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("route_idle_busy", busy, 1'b0);
    chk("route_idle_resp", resp_valid, 1'b0);

    // Backpressure: four accepted, fifth refused, then in-order drain at one per cycle
    acc_cmd_ready = 4'h0;
    for (int k = 0; k < 5; k++) begin
      cmd_e_t e;
      cmd_valid = 1'b1;
      cmd_instr = mk_instr(k % 4, 1'b0, 5'(k + 8));
      cmd_rs1   = 64'h100 + 64'(k);
      cmd_rs2   = 64'h200 + 64'(k);
      #1;
      chk("bp_cmd_ready", cmd_ready, k < 4);
      if (k < 4) begin
        e.sel = 4'b0001 << (k % 4); e.instr = cmd_instr; e.rs1 = cmd_rs1; e.rs2 = cmd_rs2;
        cmd_q.push_back(e);
      end
      tick();
    end
    cmd_valid = 1'b0;
    acc_cmd_ready = 4'hf;
    for (int k = 0; k < 4; k++) tick();
    #1;
    chk("bp_drained_busy", busy, 1'b0);
    chk("bp_drained_valid", acc_cmd_valid, 4'b0);
    chk("bp_sb_empty", cmd_q.size(), 0);

    // Outstanding cap: ninth xd=1 stalls with an xd=0 queued behind it
    for (int k = 0; k < 8; k++) push_cmd(k % 4, 1'b1, 5'(k), 64'h300 + 64'(k), 64'h0);
    push_cmd(1, 1'b1, 5'd20, 64'h399, 64'h1);
    push_cmd(3, 1'b0, 5'd21, 64'h3aa, 64'h2);
    tick();
    tick();
    chk("cap_stall_valid", acc_cmd_valid, 4'b0);
    chk("cap_busy", busy, 1'b1);
    chk("cap_cmd_ready", cmd_ready, 1'b1);
    acc_resp_data[63:0] = 64'hB0;
    acc_resp_rd[4:0] = 5'd5;
    acc_resp_valid = 4'b0001;
    tick();
    acc_resp_valid = 4'b0;
    resp_ready = 1'b1;
    #1;
    chk("cap_stall_hold", acc_cmd_valid, 4'b0);
    tick();
    resp_ready = 1'b0;
    #1;
    chk("cap_ninth", acc_cmd_valid, 4'b0010);
    tick();
    chk("cap_tenth", acc_cmd_valid, 4'b1000);
    tick();
    chk("cap_done", acc_cmd_valid, 4'b0);
    chk("cap_sb_empty", cmd_q.size(), 0);

    // Reset with both buffers full
    acc_cmd_ready = 4'h0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc_resp_data[i*64 +: 64] = 64'hC0 + 64'(i);
      acc_resp_rd[i*5 +: 5] = 5'(i + 10);
    end
    acc_resp_valid = 4'hf;
    for (int k = 0; k < 4; k++) push_cmd(k, 1'b0, 5'(k), 64'h400 + 64'(k), 64'h0);
    #1;
    chk("full_cmd_ready", cmd_ready, 1'b0);
    chk("full_resp_valid", resp_valid, 1'b1);
    chk("full_acc_resp_ready", acc_resp_ready, 4'b0);
    chk("full_busy", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    acc_resp_valid = 4'h0;
    cmd_q.delete();
    resp_q.delete();
    m_cnt = 0;
    m_ptr = 0;
    #1;
    chk("arst_resp_valid", resp_valid, 1'b0);
    chk("arst_cmd_ready", cmd_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_acc_cmd_valid", acc_cmd_valid, 4'b0);
    chk("arst_instr", acc_cmd_instr, 32'h0);
    chk("arst_resp_data", resp_data, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Arbitration with all four responders held valid
`ifdef ROCC_DISPATCH_RR_EN
    arb_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    arb_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    resp_ready = 1'b1;
    acc_resp_valid = 4'hf;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("arb_grant_%0d", c), acc_resp_ready, arb_seq[c]);
      tick();
    end
    acc_resp_valid = 4'h0;
    tick();
    tick();
    chk("arb_drained", resp_valid, 1'b0);
    resp_ready = 1'b0;

    // Illegal index on the three-accelerator instance
    c3_cmd_instr = mk_instr(3, 1'b0, 5'd9);
    c3_cmd_valid = 1'b1;
    tick();
    c3_cmd_valid = 1'b0;
    #1;
    chk("ill_err", c3_err, 1'b1);
    chk("ill_valid", c3_acc_cmd_valid, 3'b000);
    chk("ill_busy", c3_busy, 1'b1);
    tick();
    chk("ill_err_pulse", c3_err, 1'b0);
    chk("ill_empty", c3_busy, 1'b0);
    c3_cmd_instr = mk_instr(6, 1'b0, 5'd2);
    c3_cmd_valid = 1'b1;
    tick();
    c3_cmd_valid = 1'b0;
    #1;
    chk("c3_legal_valid", c3_acc_cmd_valid, 3'b100);
    chk("c3_legal_err", c3_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
